fft_frame_src: RTL and testbench

FFT_FRAME_SRC -- requirements
Module: fft_frame_src

---
 rtl/fft_frame_src.sv | 137 +++++++++++++
 tb/tb_fft_frame_src.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_src.sv
// Frame source for the FFT core: converts ADC codes to signed samples, buffers them
// in a small FWFT FIFO and streams exactly FRAME_LEN beats per frame over AXI-Stream.
module fft_frame_src #(
   parameter int FRAME_LEN = 4096,
   parameter int OFFSET    = 512
) (
   input  logic        clk_1_6384m,
   input  logic        rst,
   input  logic [9:0]  ad_data,
   input  logic        ad_otr,
   input  logic        sample_en,
   input  logic        start,
   input  logic        cont,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        busy,
   output logic        frame_done,
   output logic [12:0] otr_cnt,
   output logic        ovf
);

   localparam int CW = $clog2(FRAME_LEN) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cap_cnt, out_cnt;
   logic [15:0]   fifo_mem [4];
   logic [1:0]    wr_ptr, rd_ptr;
   logic [2:0]    fifo_cnt;
   logic [15:0]   sample_val;
   logic          fifo_full, pop, push, drop, push_req;
   logic          last_push, last_pop, frame_start, clear_ovf;

   // Over-range samples are clamped to the rail indicated by the MSB of the code
   always_comb begin
      if (ad_otr)
         sample_val = ad_data[9] ? 16'h01FF : 16'hFE00;
      else
         sample_val = {6'd0, ad_data} - 16'(OFFSET);
   end

   assign fifo_full     = (fifo_cnt == 3'd4);
   assign m_axis_tvalid = (fifo_cnt != 3'd0);
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign push_req      = (state == CAPTURE) && sample_en;
   assign push          = push_req && (!fifo_full || pop);
   assign drop          = push_req && fifo_full && !pop;
   assign last_push     = push && (cap_cnt == LAST_IDX);
   assign last_pop      = pop && (out_cnt == LAST_IDX);
   assign m_axis_tlast  = m_axis_tvalid && (out_cnt == LAST_IDX);
   assign m_axis_tdata  = m_axis_tvalid ? {16'h0000, fifo_mem[rd_ptr]} : 32'h0;
   assign busy          = (state != IDLE);

   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      clear_ovf   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt   = CAPTURE;
               frame_start = 1'b1;
               clear_ovf   = 1'b1;
            end
         end
         CAPTURE: begin
            if (last_push)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            // A restart from DRAIN keeps ovf so the host can still see it
            if (last_pop) begin
               if (cont || start) begin
                  state_nxt   = CAPTURE;
                  frame_start = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_1_6384m) begin
      if (rst) begin
         state      <= IDLE;
         cap_cnt    <= '0;
         out_cnt    <= '0;
         otr_cnt    <= '0;
         ovf        <= 1'b0;
         frame_done <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         frame_done <= (state == DRAIN) && last_pop;
         fifo_cnt   <= fifo_cnt + {2'b00, push} - {2'b00, pop};
         if (push)
            wr_ptr <= wr_ptr + 2'd1;
         if (pop)
            rd_ptr <= rd_ptr + 2'd1;

         if (frame_start)
            cap_cnt <= '0;
         else if (push)
            cap_cnt <= cap_cnt + 1'b1;

         if (frame_start || last_pop)
            out_cnt <= '0;
         else if (pop)
            out_cnt <= out_cnt + 1'b1;

         if (frame_start)
            otr_cnt <= '0;
         else if (push && ad_otr && otr_cnt != 13'h1FFF)
            otr_cnt <= otr_cnt + 13'd1;

         if (clear_ovf)
            ovf <= 1'b0;
         else if (drop)
            ovf <= 1'b1;
      end
   end

   // Storage needs no reset: the head is masked to zero while the FIFO is empty
   always_ff @(posedge clk_1_6384m) begin
      if (push)
         fifo_mem[wr_ptr] <= sample_val;
   end

endmodule

// File: tb/tb_fft_frame_src.sv
// Scoreboard bench for fft_frame_src with FRAME_LEN=16: a behavioural model queues
// expected beats as samples are driven and compares them as the DUT emits them.
module tb_fft_frame_src;

   localparam int FL = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  ad_data = '0;
   logic        ad_otr = 1'b0;
   logic        sample_en = 1'b0;
   logic        start = 1'b0;
   logic        cont = 1'b0;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic        busy;
   logic        frame_done;
   logic [12:0] otr_cnt;
   logic        ovf;

   always #5 clk = ~clk;

   fft_frame_src #(.FRAME_LEN(FL), .OFFSET(512)) dut (
      .clk_1_6384m   (clk),
      .rst           (rst),
      .ad_data       (ad_data),
      .ad_otr        (ad_otr),
      .sample_en     (sample_en),
      .start         (start),
      .cont          (cont),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .busy          (busy),
      .frame_done    (frame_done),
      .otr_cnt       (otr_cnt),
      .ovf           (ovf)
   );

   typedef enum {M_IDLE, M_CAP, M_DRAIN} mstate_t;
   typedef struct {
      logic [9:0]  d;
      logic        otr;
      logic [15:0] exp;
   } vec_t;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] q[$];
   logic [15:0] exp_val = '0;
   mstate_t     mst = M_IDLE;
   int          mcap = 0, mbeat = 0, motr = 0;
   bit          movf = 0, mdone = 0;
   int          beat_cnt = 0, tlast_cnt = 0, done_cnt = 0;
   int          tlast_beats[$];
   bit          idle_gap = 0;
   vec_t        tbl[8];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic en, input logic [9:0] d, input logic otr, input logic [15:0] e);
      sample_en = en;
      ad_data   = d;
      ad_otr    = otr;
      exp_val   = e;
   endtask

   task automatic clear_counts();
      beat_cnt  = 0;
      tlast_cnt = 0;
      done_cnt  = 0;
      idle_gap  = 0;
      tlast_beats.delete();
   endtask

   // One clock: compare pre-edge outputs, advance the model across the edge, compare again
   task automatic tick();
      bit pop_m, push_m, last_pop;
      if (!rst) begin
         check_output("tvalid", m_axis_tvalid, q.size() != 0);
         check_output("tlast", m_axis_tlast, (q.size() != 0) && (mbeat == FL - 1));
         if (q.size() != 0)
            check_output("tdata", m_axis_tdata, {16'h0000, q[0]});
         if (m_axis_tvalid && m_axis_tready) begin
            if (m_axis_tlast) begin
               tlast_cnt++;
               tlast_beats.push_back(beat_cnt + 1);
            end
            beat_cnt++;
         end
      end
      pop_m    = !rst && (q.size() != 0) && m_axis_tready;
      last_pop = pop_m && (mbeat == FL - 1);
      push_m   = !rst && (mst == M_CAP) && sample_en && ((q.size() < 4) || pop_m);
      @(posedge clk);
      #1;
      if (rst) begin
         mst = M_IDLE; q.delete(); mcap = 0; mbeat = 0; motr = 0; movf = 0; mdone = 0;
      end else begin
         mdone = (mst == M_DRAIN) && last_pop;
         if (pop_m) begin
            void'(q.pop_front());
            mbeat = last_pop ? 0 : mbeat + 1;
         end
         if ((mst == M_CAP) && sample_en && !push_m)
            movf = 1;
         if (push_m) begin
            q.push_back(exp_val);
            mcap++;
            if (ad_otr && motr < 8191)
               motr++;
         end
         case (mst)
            M_IDLE: if (start) begin
               mst = M_CAP; mcap = 0; motr = 0; movf = 0; mbeat = 0;
            end
            M_CAP: if (push_m && mcap == FL) mst = M_DRAIN;
            M_DRAIN: if (last_pop) begin
               if (cont || start) begin
                  mst = M_CAP; mcap = 0; motr = 0; mbeat = 0;
               end else begin
                  mst = M_IDLE;
               end
            end
            default: mst = M_IDLE;
         endcase
      end
      if (frame_done)
         done_cnt++;
      check_output("frame_done", frame_done, mdone);
      check_output("busy", busy, mst != M_IDLE);
      check_output("otr_cnt", otr_cnt, motr);
      check_output("ovf", ovf, movf);
   endtask

   task automatic start_frame();
      start = 1'b1;
      apply_stimulus(1'b0, 10'd0, 1'b0, 16'h0);
      tick();
      start = 1'b0;
   endtask

   // Ramp samples until the frame has drained; optional stall window and stray start
   task automatic ramp(input int max, input int stall_at, input int stall_len, input int start_at);
      logic [9:0] d;
      for (int i = 0; i < max; i++) begin
         if (mst == M_IDLE && q.size() == 0)
            break;
         m_axis_tready = !(i >= stall_at && i < stall_at + stall_len);
         start = (i == start_at);
         if (done_cnt >= 1)
            cont = 1'b0;
         d = 10'(512 + i);
         apply_stimulus(1'b1, d, 1'b0, 16'(i));
         tick();
         if (done_cnt == 1 && !busy)
            idle_gap = 1;
      end
      start = 1'b0;
      m_axis_tready = 1'b1;
      apply_stimulus(1'b0, 10'd0, 1'b0, 16'h0);
      check_output("frame_end_busy", busy, 1'b0);
   endtask

   initial begin
      int otr_exp;
      tbl[0] = '{10'd0,    1'b0, 16'hFE00};
      tbl[1] = '{10'd1023, 1'b0, 16'h01FF};
      tbl[2] = '{10'd1000, 1'b1, 16'h01FF};
      tbl[3] = '{10'd512,  1'b0, 16'h0000};
      tbl[4] = '{10'd511,  1'b0, 16'hFFFF};
      tbl[5] = '{10'd100,  1'b1, 16'hFE00};
      tbl[6] = '{10'd527,  1'b0, 16'h000F};
      tbl[7] = '{10'd700,  1'b0, 16'h00BC};

      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_output("rst_tvalid", m_axis_tvalid, 1'b0);
      check_output("rst_tlast", m_axis_tlast, 1'b0);
      check_output("rst_tdata", m_axis_tdata, 32'h0);
      check_output("rst_busy", busy, 1'b0);
      check_output("rst_otr_cnt", otr_cnt, 13'd0);
      check_output("rst_ovf", ovf, 1'b0);

      // Basic ramp frame 512..527 -> 0..15
      clear_counts();
      start_frame();
      ramp(60, -1, 0, -1);
      check_output("ramp_beats", beat_cnt, 16);
      check_output("ramp_tlasts", tlast_cnt, 1);
      check_output("ramp_done", done_cnt, 1);
      if (tlast_beats.size() >= 1)
         check_output("ramp_tlast_pos", tlast_beats[0], 16);

      // Conversion table, two passes per frame
      clear_counts();
      start_frame();
      otr_exp = 0;
      for (int i = 0; i < FL; i++) begin
         apply_stimulus(1'b1, tbl[i % 8].d, tbl[i % 8].otr, tbl[i % 8].exp);
         tick();
         otr_exp += int'(tbl[i % 8].otr);
         check_output("tbl_otr_cnt", otr_cnt, otr_exp);
      end
      ramp(40, -1, 0, -1);
      check_output("tbl_beats", beat_cnt, 16);
      check_output("tbl_otr_total", otr_cnt, 13'd4);

      // Downstream stall overflows the FIFO
      clear_counts();
      start_frame();
      ramp(100, 5, 6, -1);
      check_output("stall_ovf", ovf, 1'b1);
      check_output("stall_beats", beat_cnt, 16);
      check_output("stall_tlasts", tlast_cnt, 1);

      // Continuous mode: two back-to-back frames
      clear_counts();
      cont = 1'b1;
      start_frame();
      ramp(200, -1, 0, -1);
      check_output("cont_beats", beat_cnt, 32);
      check_output("cont_tlasts", tlast_cnt, 2);
      check_output("cont_done", done_cnt, 2);
      check_output("cont_idle_gap", idle_gap, 1'b0);
      if (tlast_beats.size() >= 2) begin
         check_output("cont_tlast1", tlast_beats[0], 16);
         check_output("cont_tlast2", tlast_beats[1], 32);
      end

      // Reset in mid-frame after 7 beats
      clear_counts();
      start_frame();
      for (int i = 0; i < 100 && beat_cnt < 7; i++) begin
         apply_stimulus(1'b1, 10'd600, 1'b1, 16'h01FF);
         tick();
      end
      check_output("pre_rst_otr", otr_cnt != 13'd0, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      apply_stimulus(1'b0, 10'd0, 1'b0, 16'h0);
      check_output("mid_rst_tvalid", m_axis_tvalid, 1'b0);
      check_output("mid_rst_busy", busy, 1'b0);
      check_output("mid_rst_otr", otr_cnt, 13'd0);
      clear_counts();
      start_frame();
      ramp(60, -1, 0, -1);
      check_output("post_rst_beats", beat_cnt, 16);
      check_output("post_rst_tlasts", tlast_cnt, 1);

      // Stray start during capture is ignored
      clear_counts();
      start_frame();
      ramp(60, -1, 0, 3);
      check_output("stray_beats", beat_cnt, 16);
      check_output("stray_tlasts", tlast_cnt, 1);
      check_output("stray_done", done_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
